al_data_ram_pgated: RTL

AL_DATA_RAM_PGATED -- requirements
Module: al_data_ram_pgated

---
 rtl/al_ram_pkg.sv | 12 +
 rtl/al_data_ram_pgated_if.sv | 33 +++
 rtl/al_data_bank.sv | 34 +++
 rtl/al_data_ram_pgated.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/al_ram_pkg.sv
// Shared types for the power-gated active-list data RAM.
package al_ram_pkg;

    localparam int unsigned WAKE_CNT_W = 4;

    typedef enum logic [1:0] {
        StOff,
        StWake,
        StOn
    } part_state_e;

endpackage

// File: rtl/al_data_ram_pgated_if.sv
// Dispatch-write, commit-read and power-control bundle of the gated data RAM.
interface al_data_ram_pgated_if #(
    parameter int unsigned RPORT     = 4,
    parameter int unsigned WPORT     = 4,
    parameter int unsigned INDEX     = 7,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_PARTS = 4
);
    logic [RPORT-1:0][INDEX-1:0] rdAddr_i;
    logic [RPORT-1:0][WIDTH-1:0] rdData_o;
    logic [WPORT-1:0][INDEX-1:0] wrAddr_i;
    logic [WPORT-1:0][WIDTH-1:0] wrData_i;
    logic [WPORT-1:0]            we_i;
    logic [WPORT-1:0]            dispatchLaneActive_i;
    logic [RPORT-1:0]            commitLaneActive_i;
    logic [NUM_PARTS-1:0]        alPartitionActive_i;
    logic                        alDataReady_o;
    logic [NUM_PARTS-1:0]        partOn_o;
    logic [WPORT-1:0]            wrDropped_o;

    modport master (
        output rdAddr_i, wrAddr_i, wrData_i, we_i, dispatchLaneActive_i,
               commitLaneActive_i, alPartitionActive_i,
        input  rdData_o, alDataReady_o, partOn_o, wrDropped_o
    );

    modport slave (
        input  rdAddr_i, wrAddr_i, wrData_i, we_i, dispatchLaneActive_i,
               commitLaneActive_i, alPartitionActive_i,
        output rdData_o, alDataReady_o, partOn_o, wrDropped_o
    );

endinterface

// File: rtl/al_data_bank.sv
// One partition of the data RAM: multi-write, async multi-read, no reset.
module al_data_bank #(
    parameter int unsigned RPORT   = 4,
    parameter int unsigned WPORT   = 4,
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned WIDTH   = 32,
    localparam int unsigned AW     = $clog2(ENTRIES)
) (
    input  logic                        clk,
    input  logic [WPORT-1:0]            we,
    input  logic [WPORT-1:0][AW-1:0]    waddr,
    input  logic [WPORT-1:0][WIDTH-1:0] wdata,
    input  logic [RPORT-1:0][AW-1:0]    raddr,
    output logic [RPORT-1:0][WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    // Later iterations override earlier ones, so the highest port wins.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WPORT; w++) begin
            if (we[w]) begin
                mem[waddr[w]] <= wdata[w];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < RPORT; r++) begin
            rdata[r] = mem[raddr[r]];
        end
    end

endmodule

// File: rtl/al_data_ram_pgated.sv
// Partitioned active-list data RAM with per-partition OFF/WAKE/ON power gating.
module al_data_ram_pgated
    import al_ram_pkg::*;
#(
    parameter int unsigned RPORT       = 4,
    parameter int unsigned WPORT       = 4,
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_PARTS   = 4,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned READ_LAT    = 1
) (
    input logic                clk,
    input logic                reset,
    al_data_ram_pgated_if.slave bus
);

    localparam int unsigned INDEX  = $clog2(DEPTH);
    localparam int unsigned PIDX   = $clog2(NUM_PARTS);
    localparam int unsigned PSELW  = (PIDX > 0) ? PIDX : 1;
    localparam int unsigned BIDX   = INDEX - PIDX;
    localparam int unsigned BDEPTH = DEPTH / NUM_PARTS;
    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);

    function automatic logic [PSELW-1:0] part_sel(input logic [INDEX-1:0] addr);
        if (NUM_PARTS == 1) return '0;
        else return PSELW'(addr >> BIDX);
    endfunction

    part_state_e           state_q [NUM_PARTS];
    part_state_e           state_d [NUM_PARTS];
    logic [WAKE_CNT_W-1:0] cnt_q   [NUM_PARTS];
    logic [WAKE_CNT_W-1:0] cnt_d   [NUM_PARTS];
    logic [NUM_PARTS-1:0]  on;
    logic                  ready_q, ready_d;
    logic [WPORT-1:0]      drop_q;

    always_comb begin
        for (int p = 0; p < NUM_PARTS; p++) begin
            state_d[p] = state_q[p];
            cnt_d[p]   = cnt_q[p];
            unique case (state_q[p])
                StOff: begin
                    if (bus.alPartitionActive_i[p]) begin
                        state_d[p] = StWake;
                        cnt_d[p]   = '0;
                    end
                end
                StWake: begin
                    if (!bus.alPartitionActive_i[p]) begin
                        state_d[p] = StOff;
                        cnt_d[p]   = '0;
                    end else if (cnt_q[p] == WAKE_LAST) begin
                        state_d[p] = StOn;
                    end else begin
                        cnt_d[p] = cnt_q[p] + WAKE_CNT_W'(1);
                    end
                end
                StOn: begin
                    if (!bus.alPartitionActive_i[p]) begin
                        state_d[p] = StOff;
                        cnt_d[p]   = '0;
                    end
                end
                default: begin
                    state_d[p] = StOff;
                    cnt_d[p]   = '0;
                end
            endcase
            on[p] = (state_q[p] == StOn);
        end
        ready_d = &(~bus.alPartitionActive_i | on);
    end

    // Write gating: a request into a non-ON partition is dropped and flagged.
    logic [WPORT-1:0]                  wr_req, wr_hit;
    logic [WPORT-1:0][PSELW-1:0]       wr_sel;
    logic [WPORT-1:0][BIDX-1:0]        bank_waddr;
    logic [NUM_PARTS-1:0][WPORT-1:0]   bank_we;

    always_comb begin
        bank_we = '0;
        for (int w = 0; w < WPORT; w++) begin
            wr_sel[w]     = part_sel(bus.wrAddr_i[w]);
            bank_waddr[w] = BIDX'(bus.wrAddr_i[w]);
            wr_req[w]     = bus.we_i[w] && bus.dispatchLaneActive_i[w];
            wr_hit[w]     = wr_req[w] && on[wr_sel[w]];
            for (int p = 0; p < NUM_PARTS; p++) begin
                bank_we[p][w] = wr_hit[w] && (wr_sel[w] == PSELW'(p));
            end
        end
    end

    logic [NUM_PARTS-1:0][RPORT-1:0][WIDTH-1:0] bank_rdata;
    logic [RPORT-1:0][BIDX-1:0]                 bank_raddr;
    logic [RPORT-1:0][PSELW-1:0]                rd_sel;
    logic [RPORT-1:0][WIDTH-1:0]                rd_data;

    always_comb begin
        for (int r = 0; r < RPORT; r++) begin
            rd_sel[r]     = part_sel(bus.rdAddr_i[r]);
            bank_raddr[r] = BIDX'(bus.rdAddr_i[r]);
            rd_data[r]    = (bus.commitLaneActive_i[r] && on[rd_sel[r]]) ?
                            bank_rdata[rd_sel[r]][r] : '0;
        end
    end

    for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
        al_data_bank #(
            .RPORT  (RPORT),
            .WPORT  (WPORT),
            .ENTRIES(BDEPTH),
            .WIDTH  (WIDTH)
        ) u_bank (
            .clk  (clk),
            .we   (bank_we[p]),
            .waddr(bank_waddr),
            .wdata(bus.wrData_i),
            .raddr(bank_raddr),
            .rdata(bank_rdata[p])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                state_q[p] <= StOff;
                cnt_q[p]   <= '0;
            end
            ready_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
            end
            ready_q <= ready_d;
            drop_q  <= wr_req & ~wr_hit;
        end
    end

    // Registering gated data (not the address) keeps same-cycle reads pre-write.
    if (READ_LAT == 0) begin : g_rd_comb
        assign bus.rdData_o = rd_data;
    end else begin : g_rd_reg
        logic [RPORT-1:0][WIDTH-1:0] rd_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) rd_q <= '0;
            else        rd_q <= rd_data;
        end
        assign bus.rdData_o = rd_q;
    end

    assign bus.partOn_o      = on;
    assign bus.alDataReady_o = ready_q;
    assign bus.wrDropped_o   = drop_q;

endmodule
